exec_datapath_core: RTL and testbench
=====================================

Name: exec_datapath_core

Overview:
- Datapath service block for the 16-bit simple-CPU controller. It bundles three sub-blocks: a combinational 16-bit ALU with SZCV flags, a free-running 32-bit cycle counter with hold, and a single-port synchronous data RAM.
- The controller drives the operands, opcode, memory address/data and hold. It latches the results itself.

Parameters:
- DATA_W, 16, datapath and memory word width.
- MEM_AW, 12, RAM address bits used; depth is 2^MEM_AW words.
- CNT_W, 32, cycle counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  reset reset, synchronous, active-high; clock clock.
- alu_op  in  4  ALU operation select.
- alu_a  in  16  operand A.
- alu_b  in  16  operand B, or shift amount in bits [3:0].
- alu_out  out  16  combinational result.
- alu_flags  out  4  {S,Z,C,V}, combinational.
- alu_flag_write  out  1  high when alu_op updates flags.
- cnt_hold  in  1  high freezes the counter.
- cnt_out  out  32  counter value.
- mem_addr  in  16  word address; only [MEM_AW-1:0] is used, upper bits ignored.
- mem_wdata  in  16  write data.
- mem_wren  in  1  write enable.
- mem_rdata  out  16  registered read data.

Behaviour:
ALU (purely combinational, no clock, unaffected by reset):
- 0 ADD: A+B. C = carry out of bit 15. V = signed overflow.
- 1 SUB: A-B. C = borrow (1 iff A<B unsigned). V = signed overflow of A-B.
- 2 AND, 3 OR, 4 XOR: bitwise. C=0, V=0.
- 5 CMP: out = A-B, flags as SUB. The controller discards out.
- 6 MOV: out = B. C=0, V=0.
- 8 SLL: A<<n. 9 SLR: rotate A left by n. 10 SRL: logical right. 11 SRA: arithmetic right.
  - n = B[3:0].
  - C = last bit shifted/rotated out; C=0 when n=0. V=0.
- 12 IDT: out = B. 13 OUT: out = A. 15 HALT: out = 0. 7 and 14 (reserved): out = 0.
- S = out[15] and Z = (out==0) for every op.
- alu_flag_write = 1 for ops 0–6 and 8–11; 0 for 7 and 12–15. Flag outputs are still driven when it is 0.

Counter:
- Rising edge with reset=1: cnt_out <= 0. Reset has priority over cnt_hold.
- Else if cnt_hold=0: cnt_out <= cnt_out+1, wrapping 0xFFFFFFFF -> 0.
- Else hold.
- Reset value of cnt_out: 0.

Data RAM:
- Write: on a rising edge with mem_wren=1 and reset=0, mem[addr] <= mem_wdata.
- Read: every edge, mem_rdata <= mem[addr]; 1-cycle latency.
- Read-during-write to the same address returns the old contents.
- Reset: mem_rdata <= 0 and any write in that cycle is suppressed. RAM contents are not cleared by reset.
- Power-up contents: all zero.
- Address aliasing: addresses differing only above bit MEM_AW-1 map to the same word.

Simultaneous events: the three sub-blocks are independent. Any combination of ALU activity, counting and RAM access in the same cycle is legal.

Test Plan:
- ALU add/sub:
  - ADD 0x7FFF+0x0001 -> out 0x8000, S=1 Z=0 C=0 V=1, flag_write=1.
  - SUB 0x0003-0x0005 -> out 0xFFFE, S=1 C=1 V=0.
  - CMP 5,5 -> Z=1.
- ALU logic/shifts, A=0x8001:
  - SLL 1 -> 0x0002, C=1.
  - SLR 1 -> 0x0003.
  - SRL 1 -> 0x4000, C=1.
  - SRA 4 -> 0xF800.
  - SRA 0 -> 0x8001, C=0.
  - XOR 0xFFFF,0xFFFF -> 0x0000, Z=1.
- ALU pass ops:
  - MOV B=0x1234 -> 0x1234.
  - OUT A=0xABCD -> 0xABCD, flag_write=0.
  - HALT -> 0, flag_write=0.
- Counter:
  - Reset, then 10 edges with hold=0 -> 10.
  - hold=1 for 5 edges -> stays 10.
  - reset with hold=1 -> 0.
  - Preload near wrap (or force) 0xFFFFFFFF, one edge -> 0.
- RAM:
  - Write 0xBEEF@0x0010, then read 0x0010 -> 0xBEEF one cycle later.
  - Write and read same address in the same edge -> old value, then new value next cycle.
  - Read 0x1010 -> 0xBEEF (alias).
- RAM reset:
  - Write during reset is suppressed (address keeps its prior contents).
  - mem_rdata = 0 during reset.
  - Previously written data survives reset.

Source files
------------

// File: rtl/exec_datapath_core.sv
// Datapath service block for the 16-bit controller: combinational ALU with SZCV
// flags, free-running cycle counter with hold, and a single-port synchronous RAM.
module exec_datapath_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_out,
  output logic [3:0]        alu_flags,
  output logic              alu_flag_write,
  input  logic              cnt_hold,
  output logic [CNT_W-1:0]  cnt_out,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wren,
  output logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned SH_W  = 4;
  localparam int unsigned DEPTH = 2 ** MEM_AW;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_CMP  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SLR  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_IDT  = 4'd12;
  localparam logic [3:0] OP_OUT  = 4'd13;

  // ALU: wide intermediates carry the C bit alongside the result
  logic [SH_W-1:0]     sh_n;
  logic [DATA_W:0]     sum_w;
  logic [DATA_W:0]     diff_w;
  logic [DATA_W:0]     shl_w;
  logic [DATA_W:0]     shr_w;
  logic [DATA_W:0]     sra_w;
  logic [2*DATA_W-1:0] rot_w;
  logic                add_v;
  logic                sub_v;
  logic [DATA_W-1:0]   res;
  logic                flag_c;
  logic                flag_v;
  logic                flag_wr;

  assign sh_n   = alu_b[SH_W-1:0];
  assign sum_w  = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff_w = {1'b0, alu_a} - {1'b0, alu_b};
  assign shl_w  = {1'b0, alu_a} << sh_n;
  assign shr_w  = {alu_a, 1'b0} >> sh_n;
  assign sra_w  = $unsigned($signed({alu_a, 1'b0}) >>> sh_n);
  assign rot_w  = {alu_a, alu_a} << sh_n;
  assign add_v  = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (sum_w[DATA_W-1] != alu_a[DATA_W-1]);
  assign sub_v  = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (diff_w[DATA_W-1] != alu_a[DATA_W-1]);

  always_comb begin
    res     = '0;
    flag_c  = 1'b0;
    flag_v  = 1'b0;
    flag_wr = 1'b1;
    case (alu_op)
      OP_ADD: begin
        res    = sum_w[DATA_W-1:0];
        flag_c = sum_w[DATA_W];
        flag_v = add_v;
      end
      OP_SUB, OP_CMP: begin
        res    = diff_w[DATA_W-1:0];
        flag_c = diff_w[DATA_W];
        flag_v = sub_v;
      end
      OP_AND: res = alu_a & alu_b;
      OP_OR:  res = alu_a | alu_b;
      OP_XOR: res = alu_a ^ alu_b;
      OP_MOV: res = alu_b;
      OP_SLL: begin
        res    = shl_w[DATA_W-1:0];
        flag_c = shl_w[DATA_W];
      end
      // last bit rotated out of the MSB lands in bit 0
      OP_SLR: begin
        res    = rot_w[2*DATA_W-1:DATA_W];
        flag_c = (sh_n != '0) && rot_w[DATA_W];
      end
      OP_SRL: begin
        res    = shr_w[DATA_W:1];
        flag_c = shr_w[0];
      end
      OP_SRA: begin
        res    = sra_w[DATA_W:1];
        flag_c = sra_w[0];
      end
      OP_IDT: begin
        res     = alu_b;
        flag_wr = 1'b0;
      end
      OP_OUT: begin
        res     = alu_a;
        flag_wr = 1'b0;
      end
      default: begin
        res     = '0;
        flag_wr = 1'b0;
      end
    endcase
  end

  assign alu_out        = res;
  assign alu_flags      = {res[DATA_W-1], (res == '0), flag_c, flag_v};
  assign alu_flag_write = flag_wr;

  // Cycle counter; reset wins over hold
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!cnt_hold) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_out = cnt_q;

  // Data RAM: upper address bits alias, read-during-write returns old data
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [MEM_AW-1:0] addr_w;
  logic              unused_addr_hi;

  assign addr_w         = mem_addr[MEM_AW-1:0];
  assign unused_addr_hi = ^mem_addr[DATA_W-1:MEM_AW];

  always_ff @(posedge clock) begin
    if (!reset && mem_wren) mem_q[addr_w] <= mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= mem_q[addr_w];
  end

  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_exec_datapath_core.sv
// Scoreboard bench for exec_datapath_core: ALU vectors, counter hold/reset/wrap,
// RAM latency, read-during-write, aliasing and reset behaviour.
module tb_exec_datapath_core;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;
  logic [3:0]  alu_flags;
  logic        alu_flag_write;
  logic        cnt_hold;
  logic [31:0] cnt_out;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wren;
  logic [15:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [3:0]  fl;
    logic        fw;
  } alu_vec_t;

  typedef struct packed {
    logic        rst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wren;
    logic        chk;
  } ram_vec_t;

  typedef struct packed {
    logic        chk;
    logic [15:0] d;
  } ram_exp_t;

  alu_vec_t    alu_q[$];
  ram_exp_t    ram_q[$];
  logic [31:0] cnt_q[$];
  logic [15:0] mem_m [int];

  exec_datapath_core dut (
    .clock         (clock),
    .reset         (reset),
    .alu_op        (alu_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_out       (alu_out),
    .alu_flags     (alu_flags),
    .alu_flag_write(alu_flag_write),
    .cnt_hold      (cnt_hold),
    .cnt_out       (cnt_out),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wren      (mem_wren),
    .mem_rdata     (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one ALU vector and queues its expected result
  task automatic apply_alu(input alu_vec_t v);
    alu_op = v.op;
    alu_a  = v.a;
    alu_b  = v.b;
    alu_q.push_back(v);
  endtask

  // Drives one RAM cycle, predicting the read from the model before any write
  task automatic apply_ram(input ram_vec_t v);
    ram_exp_t e;
    int k;
    k        = int'(v.addr[11:0]);
    reset    = v.rst;
    mem_addr = v.addr;
    mem_wdata = v.wdata;
    mem_wren = v.wren;
    e.chk    = v.chk;
    e.d      = 16'h0;
    if (!v.rst) begin
      if (mem_m.exists(k)) e.d = mem_m[k];
      else e.chk = 1'b0;
      if (v.wren) mem_m[k] = v.wdata;
    end
    ram_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1; cnt_hold = 1'b0; mem_wren = 1'b0;
    mem_addr = 16'h0; mem_wdata = 16'h0;
    alu_op = 4'd0; alu_a = 16'h0; alu_b = 16'h0;
    step();
    step();
    total++;
    if (cnt_out !== 32'h0) begin
      bad++;
      $display("FAIL reset_cnt got=%h want=%h", cnt_out, 32'h0);
    end
    total++;
    if (mem_rdata !== 16'h0) begin
      bad++;
      $display("FAIL reset_rdata got=%h want=%h", mem_rdata, 16'h0);
    end
  endtask

  task automatic test_alu_arith();
    alu_vec_t v [5];
    alu_vec_t e;
    v[0] = {4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b1};
    v[1] = {4'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 1'b1};
    v[2] = {4'd5, 16'h0005, 16'h0005, 16'h0000, 4'b0100, 1'b1};
    v[3] = {4'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b1};
    v[4] = {4'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b1};
    for (int i = 0; i < 5; i++) begin
      apply_alu(v[i]);
      #1;
      e = alu_q.pop_front();
      total++;
      if ({alu_out, alu_flags, alu_flag_write} !== {e.out, e.fl, e.fw}) begin
        bad++;
        $display("FAIL alu_arith[%0d] got out=%h fl=%b fw=%b want out=%h fl=%b fw=%b",
                 i, alu_out, alu_flags, alu_flag_write, e.out, e.fl, e.fw);
      end
    end
  endtask

  task automatic test_alu_shift_logic();
    alu_vec_t v [9];
    alu_vec_t e;
    v[0] = {4'd8,  16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b1};
    v[1] = {4'd9,  16'h8001, 16'h0001, 16'h0003, 4'b0010, 1'b1};
    v[2] = {4'd10, 16'h8001, 16'h0001, 16'h4000, 4'b0010, 1'b1};
    v[3] = {4'd11, 16'h8001, 16'h0004, 16'hF800, 4'b1000, 1'b1};
    v[4] = {4'd11, 16'h8001, 16'h0000, 16'h8001, 4'b1000, 1'b1};
    v[5] = {4'd4,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100, 1'b1};
    v[6] = {4'd2,  16'hF0F0, 16'hFF00, 16'hF000, 4'b1000, 1'b1};
    v[7] = {4'd3,  16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 1'b1};
    v[8] = {4'd8,  16'h0001, 16'hFFFF, 16'h8000, 4'b1000, 1'b1};
    for (int i = 0; i < 9; i++) begin
      apply_alu(v[i]);
      #1;
      e = alu_q.pop_front();
      total++;
      if ({alu_out, alu_flags, alu_flag_write} !== {e.out, e.fl, e.fw}) begin
        bad++;
        $display("FAIL alu_shift_logic[%0d] got out=%h fl=%b fw=%b want out=%h fl=%b fw=%b",
                 i, alu_out, alu_flags, alu_flag_write, e.out, e.fl, e.fw);
      end
    end
  endtask

  task automatic test_alu_pass();
    alu_vec_t v [6];
    alu_vec_t e;
    v[0] = {4'd6,  16'h5555, 16'h1234, 16'h1234, 4'b0000, 1'b1};
    v[1] = {4'd13, 16'hABCD, 16'h0000, 16'hABCD, 4'b1000, 1'b0};
    v[2] = {4'd15, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1'b0};
    v[3] = {4'd12, 16'h1111, 16'h8765, 16'h8765, 4'b1000, 1'b0};
    v[4] = {4'd7,  16'h0001, 16'h0001, 16'h0000, 4'b0100, 1'b0};
    v[5] = {4'd14, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply_alu(v[i]);
      #1;
      e = alu_q.pop_front();
      total++;
      if ({alu_out, alu_flags, alu_flag_write} !== {e.out, e.fl, e.fw}) begin
        bad++;
        $display("FAIL alu_pass[%0d] got out=%h fl=%b fw=%b want out=%h fl=%b fw=%b",
                 i, alu_out, alu_flags, alu_flag_write, e.out, e.fl, e.fw);
      end
    end
  endtask

  task automatic test_counter();
    logic [31:0] m;
    logic [31:0] e;
    // phase: 0 = count 10, 1 = hold 5, 2 = reset under hold, 3 = count 1
    int len [4] = '{10, 5, 1, 1};
    m = 32'h0;
    reset = 1'b1; cnt_hold = 1'b0;
    step();
    for (int p = 0; p < 4; p++) begin
      reset    = (p == 2);
      cnt_hold = (p == 1) || (p == 2);
      for (int i = 0; i < len[p]; i++) begin
        if (reset) m = 32'h0;
        else if (!cnt_hold) m = m + 32'd1;
        cnt_q.push_back(m);
        step();
      end
      e = cnt_q.pop_back();
      cnt_q.delete();
      total++;
      if (cnt_out !== e) begin
        bad++;
        $display("FAIL counter_phase%0d got=%h want=%h", p, cnt_out, e);
      end
    end
    // wrap from all-ones
    reset = 1'b0; cnt_hold = 1'b0;
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    cnt_q.push_back(32'h0);
    step();
    e = cnt_q.pop_front();
    total++;
    if (cnt_out !== e) begin
      bad++;
      $display("FAIL counter_wrap got=%h want=%h", cnt_out, e);
    end
  endtask

  task automatic test_ram();
    ram_vec_t v [8];
    ram_exp_t e;
    v[0] = {1'b0, 16'h0010, 16'hBEEF, 1'b1, 1'b0};
    v[1] = {1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1};
    v[2] = {1'b0, 16'h0020, 16'h1111, 1'b1, 1'b0};
    v[3] = {1'b0, 16'h0020, 16'h2222, 1'b1, 1'b1};
    v[4] = {1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1};
    v[5] = {1'b0, 16'h1010, 16'h0000, 1'b0, 1'b1};
    v[6] = {1'b0, 16'hF020, 16'h3333, 1'b1, 1'b1};
    v[7] = {1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      apply_ram(v[i]);
      step();
      e = ram_q.pop_front();
      if (e.chk) begin
        total++;
        if (mem_rdata !== e.d) begin
          bad++;
          $display("FAIL ram[%0d] got=%h want=%h", i, mem_rdata, e.d);
        end
      end
    end
    mem_wren = 1'b0;
  endtask

  task automatic test_ram_reset();
    ram_vec_t v [3];
    ram_exp_t e;
    v[0] = {1'b1, 16'h0010, 16'hDEAD, 1'b1, 1'b1};
    v[1] = {1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1};
    v[2] = {1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      apply_ram(v[i]);
      step();
      e = ram_q.pop_front();
      if (e.chk) begin
        total++;
        if (mem_rdata !== e.d) begin
          bad++;
          $display("FAIL ram_reset[%0d] got=%h want=%h", i, mem_rdata, e.d);
        end
      end
    end
    mem_wren = 1'b0;
  endtask

  // All three sub-blocks active in the same cycles
  task automatic test_back_to_back();
    ram_vec_t v [4];
    ram_exp_t e;
    alu_vec_t ae;
    logic [31:0] ce;
    logic [31:0] m;
    v[0] = {1'b0, 16'h0030, 16'hA5A5, 1'b1, 1'b0};
    v[1] = {1'b0, 16'h0031, 16'h5A5A, 1'b1, 1'b0};
    v[2] = {1'b0, 16'h0030, 16'h0000, 1'b0, 1'b1};
    v[3] = {1'b0, 16'h0031, 16'h0000, 1'b0, 1'b1};
    reset = 1'b1; cnt_hold = 1'b0; mem_wren = 1'b0;
    step();
    m = 32'h0;
    for (int i = 0; i < 4; i++) begin
      apply_ram(v[i]);
      apply_alu({4'd0, 16'(i * 100), 16'h0001, 16'(i * 100 + 1), 4'b0000, 1'b1});
      m = m + 32'd1;
      cnt_q.push_back(m);
      step();
      e  = ram_q.pop_front();
      ae = alu_q.pop_front();
      ce = cnt_q.pop_front();
      total++;
      if (alu_out !== ae.out) begin
        bad++;
        $display("FAIL b2b_alu[%0d] got=%h want=%h", i, alu_out, ae.out);
      end
      total++;
      if (cnt_out !== ce) begin
        bad++;
        $display("FAIL b2b_cnt[%0d] got=%h want=%h", i, cnt_out, ce);
      end
      if (e.chk) begin
        total++;
        if (mem_rdata !== e.d) begin
          bad++;
          $display("FAIL b2b_ram[%0d] got=%h want=%h", i, mem_rdata, e.d);
        end
      end
    end
    mem_wren = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_arith();
    test_alu_shift_logic();
    test_alu_pass();
    test_counter();
    test_ram();
    test_ram_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
